// File: rtl/rr_ex_hazard_ctrl.sv
// Hazard sequencer at the RR/EX boundary: load-use bubbles, mispredict flush and STOP drain/halt.
// Optional feature macro: HAZARD_PERF_EN adds saturating ld_stall_cnt / flush_cnt counters.
module rr_ex_hazard_ctrl #(
    parameter int LD_STALL_CYC = 1,
    parameter int DRAIN_CYC    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rr_valid,
    input  logic [2:0] rr_src0_addr,
    input  logic [2:0] rr_src1_addr,
    input  logic       rr_use0,
    input  logic       rr_use1,
    input  logic       ex_valid,
    input  logic       ex_mem_ans,
    input  logic       ex_W_reg,
    input  logic [2:0] ex_RDest,
    input  logic       ex_mispredict,
    input  logic       ex_stop,
    output logic       stall_IF,
    output logic       stall_ID,
    output logic       stall_RR,
    output logic       valid_IF_ID,
    output logic       valid_ID_RR,
    output logic       valid_RR_EX,
    output logic       pc_redirect,
    output logic       halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0] ld_stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef enum logic [2:0] {RUN, LDSTALL, FLUSH, DRAIN, HALTED} state_t;

    localparam logic [2:0] LD_CNT_INIT    = 3'(LD_STALL_CYC - 1);
    localparam logic [2:0] DRAIN_CNT_INIT = 3'(DRAIN_CYC - 1);

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic       hz, stop_req, mis_req;

    // ex_valid masks every EX-originated request
    assign stop_req = ex_valid & ex_stop;
    assign mis_req  = ex_valid & ex_mispredict;
    assign hz = rr_valid & ex_valid & ex_mem_ans & ex_W_reg &
                ((rr_use0 & (rr_src0_addr == ex_RDest)) |
                 (rr_use1 & (rr_src1_addr == ex_RDest)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RUN;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            RUN: begin
                if (stop_req) begin
                    state_next = DRAIN;
                    cnt_next   = DRAIN_CNT_INIT;
                end else if (mis_req) begin
                    state_next = FLUSH;
                end else if (hz) begin
                    cnt_next   = LD_CNT_INIT;
                    state_next = (LD_STALL_CYC == 1) ? RUN : LDSTALL;
                end
            end
            LDSTALL: begin
                if (cnt_reg != 3'd0) cnt_next = cnt_reg - 3'd1;
                else                 state_next = RUN;
            end
            FLUSH:   state_next = RUN;
            DRAIN: begin
                if (cnt_reg == 3'd0) state_next = HALTED;
                else                 cnt_next   = cnt_reg - 3'd1;
            end
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        stall_IF    = 1'b0;
        stall_ID    = 1'b0;
        stall_RR    = 1'b0;
        valid_IF_ID = 1'b1;
        valid_ID_RR = 1'b1;
        valid_RR_EX = 1'b1;
        pc_redirect = 1'b0;
        halted      = 1'b0;
        if (reset) begin
            valid_IF_ID = 1'b0;
            valid_ID_RR = 1'b0;
            valid_RR_EX = 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (stop_req) begin
                        stall_IF    = 1'b1;
                        valid_IF_ID = 1'b0;
                        valid_ID_RR = 1'b0;
                        valid_RR_EX = 1'b0;
                    end else if (mis_req) begin
                        valid_IF_ID = 1'b0;
                        valid_ID_RR = 1'b0;
                        valid_RR_EX = 1'b0;
                        pc_redirect = 1'b1;
                    end else if (hz) begin
                        stall_IF    = 1'b1;
                        stall_ID    = 1'b1;
                        stall_RR    = 1'b1;
                        valid_RR_EX = 1'b0;
                    end
                end
                LDSTALL: begin
                    if (cnt_reg != 3'd0) begin
                        stall_IF    = 1'b1;
                        stall_ID    = 1'b1;
                        stall_RR    = 1'b1;
                        valid_RR_EX = 1'b0;
                    end
                end
                DRAIN: begin
                    stall_IF    = 1'b1;
                    valid_IF_ID = 1'b0;
                    valid_ID_RR = 1'b0;
                    valid_RR_EX = 1'b0;
                end
                HALTED: begin
                    stall_IF    = 1'b1;
                    stall_ID    = 1'b1;
                    stall_RR    = 1'b1;
                    valid_IF_ID = 1'b0;
                    valid_ID_RR = 1'b0;
                    valid_RR_EX = 1'b0;
                    halted      = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic ld_event, flush_event;

    // Only RUN-state entries count; a hazard hidden behind stop/mispredict is not a stall
    assign ld_event    = (state_reg == RUN) & ~stop_req & ~mis_req & hz;
    assign flush_event = (state_reg == RUN) & ~stop_req & mis_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_stall_cnt <= 16'd0;
            flush_cnt    <= 16'd0;
        end else begin
            if (ld_event && ld_stall_cnt != 16'hFFFF) ld_stall_cnt <= ld_stall_cnt + 16'd1;
            if (flush_event && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rr_ex_hazard_ctrl.sv
// Bench for rr_ex_hazard_ctrl: two instances (LD_STALL_CYC 1 and 3) checked against a cycle model.
// Define HAZARD_PERF_EN to also exercise the performance counters.
module tb_rr_ex_hazard_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, rr_valid, rr_use0, rr_use1, ex_valid, ex_mem_ans, ex_W_reg;
    logic       ex_mispredict, ex_stop;
    logic [2:0] rr_src0_addr, rr_src1_addr, ex_RDest;

    logic sIF_a, sID_a, sRR_a, vIFID_a, vIDRR_a, vRREX_a, redir_a, halt_a;
    logic sIF_b, sID_b, sRR_b, vIFID_b, vIDRR_b, vRREX_b, redir_b, halt_b;
    logic [7:0] out_a, out_b;
    assign out_a = {sIF_a, sID_a, sRR_a, vIFID_a, vIDRR_a, vRREX_a, redir_a, halt_a};
    assign out_b = {sIF_b, sID_b, sRR_b, vIFID_b, vIDRR_b, vRREX_b, redir_b, halt_b};
`ifdef HAZARD_PERF_EN
    logic [15:0] ldc_a, flc_a, ldc_b, flc_b;
`endif

    rr_ex_hazard_ctrl #(.LD_STALL_CYC(1), .DRAIN_CYC(3)) dut_a (
        .clk(clk), .reset(reset), .rr_valid(rr_valid), .rr_src0_addr(rr_src0_addr),
        .rr_src1_addr(rr_src1_addr), .rr_use0(rr_use0), .rr_use1(rr_use1), .ex_valid(ex_valid),
        .ex_mem_ans(ex_mem_ans), .ex_W_reg(ex_W_reg), .ex_RDest(ex_RDest),
        .ex_mispredict(ex_mispredict), .ex_stop(ex_stop), .stall_IF(sIF_a), .stall_ID(sID_a),
        .stall_RR(sRR_a), .valid_IF_ID(vIFID_a), .valid_ID_RR(vIDRR_a), .valid_RR_EX(vRREX_a),
        .pc_redirect(redir_a), .halted(halt_a)
`ifdef HAZARD_PERF_EN
        , .ld_stall_cnt(ldc_a), .flush_cnt(flc_a)
`endif
    );

    rr_ex_hazard_ctrl #(.LD_STALL_CYC(3), .DRAIN_CYC(3)) dut_b (
        .clk(clk), .reset(reset), .rr_valid(rr_valid), .rr_src0_addr(rr_src0_addr),
        .rr_src1_addr(rr_src1_addr), .rr_use0(rr_use0), .rr_use1(rr_use1), .ex_valid(ex_valid),
        .ex_mem_ans(ex_mem_ans), .ex_W_reg(ex_W_reg), .ex_RDest(ex_RDest),
        .ex_mispredict(ex_mispredict), .ex_stop(ex_stop), .stall_IF(sIF_b), .stall_ID(sID_b),
        .stall_RR(sRR_b), .valid_IF_ID(vIFID_b), .valid_ID_RR(vIDRR_b), .valid_RR_EX(vRREX_b),
        .pc_redirect(redir_b), .halted(halt_b)
`ifdef HAZARD_PERF_EN
        , .ld_stall_cnt(ldc_b), .flush_cnt(flc_b)
`endif
    );

    // Output patterns: {stall_IF,stall_ID,stall_RR, valid_IF_ID,valid_ID_RR,valid_RR_EX, pc_redirect, halted}
    localparam logic [7:0] P_RST = 8'b000_000_0_0;
    localparam logic [7:0] P_DEF = 8'b000_111_0_0;
    localparam logic [7:0] P_LDS = 8'b111_110_0_0;
    localparam logic [7:0] P_FLS = 8'b000_000_1_0;
    localparam logic [7:0] P_DRN = 8'b100_000_0_0;
    localparam logic [7:0] P_HLT = 8'b111_000_0_1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: remaining bubble/drain cycles per instance, plus pending one-cycle FLUSH/idle slots
    int   m_lcyc[2] = '{1, 3};
    int   m_ld[2], m_drain[2], n_ld[2], n_drain[2];
    bit   m_idle[2], m_flush[2], m_halt[2], n_idle[2], n_flush[2], n_halt[2];
    int   m_ldcnt, m_flcnt, n_ldcnt, n_flcnt;
    logic [7:0] exp_o[2];

    task automatic model_eval();
        bit hz_m;
        hz_m = rr_valid && ex_valid && ex_mem_ans && ex_W_reg &&
               ((rr_use0 && rr_src0_addr == ex_RDest) || (rr_use1 && rr_src1_addr == ex_RDest));
        n_ldcnt = m_ldcnt;
        n_flcnt = m_flcnt;
        for (int i = 0; i < 2; i++) begin
            n_ld[i] = m_ld[i]; n_drain[i] = m_drain[i]; n_idle[i] = m_idle[i];
            n_flush[i] = m_flush[i]; n_halt[i] = m_halt[i];
            if (reset) begin
                exp_o[i] = P_RST;
                n_ld[i] = 0; n_drain[i] = 0; n_idle[i] = 0; n_flush[i] = 0; n_halt[i] = 0;
                if (i == 0) begin n_ldcnt = 0; n_flcnt = 0; end
            end else if (m_halt[i]) begin
                exp_o[i] = P_HLT;
            end else if (m_drain[i] > 0) begin
                exp_o[i] = P_DRN;
                n_drain[i] = m_drain[i] - 1;
                if (n_drain[i] == 0) n_halt[i] = 1;
            end else if (m_ld[i] > 0) begin
                exp_o[i] = P_LDS;
                n_ld[i] = m_ld[i] - 1;
            end else if (m_idle[i] || m_flush[i]) begin
                exp_o[i] = P_DEF;
                n_idle[i] = 0; n_flush[i] = 0;
            end else if (ex_valid && ex_stop) begin
                exp_o[i] = P_DRN;
                n_drain[i] = 3;
            end else if (ex_valid && ex_mispredict) begin
                exp_o[i] = P_FLS;
                n_flush[i] = 1;
                if (i == 0 && m_flcnt < 65535) n_flcnt = m_flcnt + 1;
            end else if (hz_m) begin
                exp_o[i] = P_LDS;
                n_ld[i] = m_lcyc[i] - 1;
                n_idle[i] = (m_lcyc[i] > 1);
                if (i == 0 && m_ldcnt < 65535) n_ldcnt = m_ldcnt + 1;
            end else begin
                exp_o[i] = P_DEF;
            end
        end
    endtask

    task automatic model_commit();
        m_ld = n_ld; m_drain = n_drain; m_idle = n_idle; m_flush = n_flush; m_halt = n_halt;
        m_ldcnt = n_ldcnt; m_flcnt = n_flcnt;
    endtask

    task automatic drive(input logic r, input logic rv, input logic [2:0] s0, input logic [2:0] s1,
                         input logic u0, input logic u1, input logic ev, input logic mem,
                         input logic w, input logic [2:0] rd, input logic mp, input logic st);
        reset = r; rr_valid = rv; rr_src0_addr = s0; rr_src1_addr = s1; rr_use0 = u0;
        rr_use1 = u1; ex_valid = ev; ex_mem_ans = mem; ex_W_reg = w; ex_RDest = rd;
        ex_mispredict = mp; ex_stop = st;
    endtask

    task automatic idle_in(input logic r);
        drive(r, 1, 3'd1, 3'd2, 1, 1, 0, 0, 0, 3'd0, 0, 0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            idle_in(k < 2);
            @(negedge clk); model_eval();
            n_checks++;
            if (out_a !== exp_o[0] || out_b !== exp_o[1]) begin
                n_fail++;
                $display("FAIL reset k=%0d a=%b b=%b expected a=%b b=%b", k, out_a, out_b, exp_o[0], exp_o[1]);
            end
            @(posedge clk); model_commit(); #1;
        end
    endtask

    // k: 0 load-use on src1, 1 use1=0, 2 W_reg=0, 3 src0 hazard; each followed by EX bubbles
    task automatic test_load_use();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 5; c++) begin
                if (c == 0)
                    drive(0, 1, 3'd5, 3'd3, (k == 3), (k != 1), 1, 1, (k != 2), (k == 3) ? 3'd5 : 3'd3, 0, 0);
                else
                    idle_in(0);
                @(negedge clk); model_eval();
                n_checks++;
                if (out_a !== exp_o[0] || out_b !== exp_o[1]) begin
                    n_fail++;
                    $display("FAIL load_use k=%0d c=%0d a=%b b=%b expected a=%b b=%b", k, c, out_a, out_b, exp_o[0], exp_o[1]);
                end
                @(posedge clk); model_commit(); #1;
            end
        end
    endtask

    task automatic test_mispredict();
        for (int c = 0; c < 4; c++) begin
            if (c < 2) drive(0, 1, 3'd3, 3'd3, 1, 1, 1, 1, 1, 3'd3, 1, 0);
            else       idle_in(0);
            @(negedge clk); model_eval();
            n_checks++;
            if (out_a !== exp_o[0] || out_b !== exp_o[1]) begin
                n_fail++;
                $display("FAIL mispredict c=%0d a=%b b=%b expected a=%b b=%b", c, out_a, out_b, exp_o[0], exp_o[1]);
            end
            @(posedge clk); model_commit(); #1;
        end
    endtask

    task automatic test_stop_drain();
        for (int c = 0; c < 19; c++) begin
            if (c == 0)       drive(0, 1, 3'd1, 3'd1, 1, 1, 1, 1, 1, 3'd1, 1, 1);
            else if (c == 16) idle_in(1);
            else              drive(0, 1, 3'd2, 3'd2, 1, 1, 1, 1, 1, 3'd2, (c % 2), 0);
            @(negedge clk); model_eval();
            n_checks++;
            if (out_a !== exp_o[0] || out_b !== exp_o[1]) begin
                n_fail++;
                $display("FAIL stop_drain c=%0d a=%b b=%b expected a=%b b=%b", c, out_a, out_b, exp_o[0], exp_o[1]);
            end
            @(posedge clk); model_commit(); #1;
        end
    endtask

    // Reset lands while the LD_STALL_CYC=3 instance is mid-bubble
    task automatic test_reset_mid_stall();
        for (int c = 0; c < 5; c++) begin
            if (c == 0)      drive(0, 1, 3'd4, 3'd0, 1, 0, 1, 1, 1, 3'd4, 0, 0);
            else if (c == 2) idle_in(1);
            else             idle_in(0);
            @(negedge clk); model_eval();
            n_checks++;
            if (out_a !== exp_o[0] || out_b !== exp_o[1]) begin
                n_fail++;
                $display("FAIL reset_mid_stall c=%0d a=%b b=%b expected a=%b b=%b", c, out_a, out_b, exp_o[0], exp_o[1]);
            end
            @(posedge clk); model_commit(); #1;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(99) < 3), ($urandom_range(9) < 8),
                  3'($urandom_range(3)), 3'($urandom_range(3)), 1'($urandom), 1'($urandom),
                  ($urandom_range(9) < 8), 1'($urandom), ($urandom_range(9) < 7),
                  3'($urandom_range(3)), ($urandom_range(9) == 0), ($urandom_range(99) < 2));
            @(negedge clk); model_eval();
            n_checks++;
            if (out_a !== exp_o[0] || out_b !== exp_o[1]) begin
                n_fail++;
                $display("FAIL random c=%0d a=%b b=%b expected a=%b b=%b", c, out_a, out_b, exp_o[0], exp_o[1]);
            end
            @(posedge clk); model_commit(); #1;
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        idle_in(1);
        @(negedge clk); model_eval(); @(posedge clk); model_commit(); #1;
        for (int c = 0; c < 12; c++) begin
            if (c % 3 != 0)  idle_in(0);
            else if (c < 12) drive(0, 1, 3'd6, 3'd6, 1, 0, 1, 1, 1, 3'd6, 0, 0);
            if (c == 1 || c == 7) drive(0, 1, 3'd0, 3'd0, 0, 0, 1, 0, 0, 3'd0, 1, 0);
            @(negedge clk); model_eval(); @(posedge clk); model_commit(); #1;
        end
        idle_in(0);
        @(negedge clk);
        n_checks++;
        if (ldc_a !== 16'(m_ldcnt) || m_ldcnt != 4) begin
            n_fail++;
            $display("FAIL perf_ld_cnt got %0d expected 4 (model %0d)", ldc_a, m_ldcnt);
        end
        n_checks++;
        if (flc_a !== 16'(m_flcnt) || m_flcnt != 2) begin
            n_fail++;
            $display("FAIL perf_flush_cnt got %0d expected 2 (model %0d)", flc_a, m_flcnt);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 65540; c++) begin
            drive(0, 1, 3'd7, 3'd7, 1, 1, 1, 1, 1, 3'd7, 0, 0);
            @(negedge clk); model_eval(); @(posedge clk); model_commit(); #1;
        end
        idle_in(0);
        @(negedge clk);
        n_checks++;
        if (ldc_a !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL perf_ld_saturate got %h expected ffff", ldc_a);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        idle_in(1);
        for (int i = 0; i < 2; i++) begin
            m_ld[i] = 0; m_drain[i] = 0; m_idle[i] = 0; m_flush[i] = 0; m_halt[i] = 0;
        end
        m_ldcnt = 0; m_flcnt = 0;
        test_reset();
        test_load_use();
        test_mispredict();
        test_stop_drain();
        test_reset_mid_stall();
        test_random();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
